// File: rtl/matrix_bank.sv
// Multi-slot matrix store: row-major element fill into FIFO-chosen or explicit slots, registered random-access read.
// Read latency 1 cycle; no backpressure, every elem_valid cycle is consumed (or dropped when idle).
module matrix_bank #(
  parameter int MAX_DIM    = 5,
  parameter int MAX_STORE  = 4,
  parameter int ELEM_WIDTH = 8,
  parameter int DIM_WIDTH  = 4,
  localparam int SLOT_W    = (MAX_STORE > 1) ? $clog2(MAX_STORE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DIM_WIDTH-1:0]  m,
  input  logic [DIM_WIDTH-1:0]  n,
  input  logic                  wr_mode,
  input  logic [SLOT_W-1:0]     wr_slot,
  input  logic [ELEM_WIDTH-1:0] elem_in,
  input  logic                  elem_valid,
  input  logic                  elem_end,
  input  logic                  abort,
  input  logic                  rd_en,
  input  logic [SLOT_W-1:0]     rd_slot,
  input  logic [DIM_WIDTH-1:0]  rd_row,
  input  logic [DIM_WIDTH-1:0]  rd_col,
  output logic [ELEM_WIDTH-1:0] rd_data,
  output logic [DIM_WIDTH-1:0]  rd_m,
  output logic [DIM_WIDTH-1:0]  rd_n,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [MAX_STORE-1:0]  slot_valid,
  output logic                  busy,
  output logic                  input_done,
  output logic                  dim_err
);

  localparam int IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [DIM_WIDTH-1:0] MAX_DIM_D = DIM_WIDTH'(MAX_DIM);
  localparam logic [SLOT_W:0]      NUM_SLOT  = (SLOT_W+1)'(MAX_STORE);
  localparam logic [SLOT_W-1:0]    LAST_SLOT = SLOT_W'(MAX_STORE - 1);

  typedef struct packed {
    logic [DIM_WIDTH-1:0] m;
    logic [DIM_WIDTH-1:0] n;
  } dims_t;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state;
  logic [ELEM_WIDTH-1:0] mem [MAX_STORE][MAX_DIM][MAX_DIM];
  dims_t                 dims [MAX_STORE];
  dims_t                 act;
  logic [SLOT_W-1:0]     tgt_slot;
  logic [SLOT_W-1:0]     fifo_ptr;
  logic [DIM_WIDTH-1:0]  row_cnt;
  logic [DIM_WIDTH-1:0]  col_cnt;

  logic                  wen_ok;
  logic [SLOT_W-1:0]     new_slot;
  logic                  last_elem;
  logic                  rd_slot_vld;
  logic                  rd_hit_c;
  logic [ELEM_WIDTH-1:0] rd_elem;

  assign wen_ok = (m != '0) && (m <= MAX_DIM_D) && (n != '0) && (n <= MAX_DIM_D) &&
                  (!wr_mode || ({1'b0, wr_slot} < NUM_SLOT));
  assign new_slot  = wr_mode ? wr_slot : fifo_ptr;
  assign last_elem = elem_valid && (row_cnt == act.m - 1'b1) && (col_cnt == act.n - 1'b1);

  // Out-of-range slots and addresses read as a miss; the array index is only trusted under rd_hit_c.
  assign rd_slot_vld = ({1'b0, rd_slot} < NUM_SLOT) && slot_valid[rd_slot];
  assign rd_hit_c    = rd_slot_vld && (rd_row < dims[rd_slot].m) && (rd_col < dims[rd_slot].n);
  assign rd_elem     = mem[rd_slot][rd_row[IDX_W-1:0]][rd_col[IDX_W-1:0]];

  assign busy = (state == FILL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      act        <= '0;
      tgt_slot   <= '0;
      fifo_ptr   <= '0;
      row_cnt    <= '0;
      col_cnt    <= '0;
      slot_valid <= '0;
      input_done <= 1'b0;
      dim_err    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_hit     <= 1'b0;
      rd_data    <= '0;
      rd_m       <= '0;
      rd_n       <= '0;
      for (int s = 0; s < MAX_STORE; s++) begin
        dims[s] <= '0;
        for (int r = 0; r < MAX_DIM; r++)
          for (int c = 0; c < MAX_DIM; c++)
            mem[s][r][c] <= '0;
      end
    end else begin
      input_done <= 1'b0;
      dim_err    <= 1'b0;

      // A new wen wins over everything on the write side, even a mid-fill element.
      if (wen) begin
        if (wen_ok) begin
          tgt_slot             <= new_slot;
          act                  <= '{m: m, n: n};
          dims[new_slot]       <= '{m: m, n: n};
          slot_valid[new_slot] <= 1'b0;
          row_cnt              <= '0;
          col_cnt              <= '0;
          state                <= FILL;
          if (!wr_mode)
            fifo_ptr <= (fifo_ptr == LAST_SLOT) ? '0 : fifo_ptr + 1'b1;
          for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++)
              mem[new_slot][r][c] <= '0;
        end else begin
          dim_err <= 1'b1;
        end
      end else if (state == FILL) begin
        if (abort) begin
          state <= IDLE;
        end else begin
          if (elem_valid)
            mem[tgt_slot][row_cnt[IDX_W-1:0]][col_cnt[IDX_W-1:0]] <= elem_in;
          if (last_elem || elem_end) begin
            slot_valid[tgt_slot] <= 1'b1;
            input_done           <= 1'b1;
            state                <= IDLE;
          end else if (elem_valid) begin
            if (col_cnt == act.n - 1'b1) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
      end

      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit  <= rd_hit_c;
        rd_data <= rd_hit_c ? rd_elem : '0;
        rd_m    <= rd_slot_vld ? dims[rd_slot].m : '0;
        rd_n    <= rd_slot_vld ? dims[rd_slot].n : '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_bank.sv
// Directed bench for matrix_bank with a behavioural storage model and a read-result scoreboard.
module tb_matrix_bank;
  localparam int MD = 5;
  localparam int MS = 4;
  localparam int EW = 8;
  localparam int DW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen, wr_mode, elem_valid, elem_end, abort, rd_en;
  logic [DW-1:0] m, n, rd_row, rd_col;
  logic [SW-1:0] wr_slot, rd_slot;
  logic [EW-1:0] elem_in, rd_data;
  logic [DW-1:0] rd_m, rd_n;
  logic          rd_valid, rd_hit, busy, input_done, dim_err;
  logic [MS-1:0] slot_valid;

  always #5 clk = ~clk;

  matrix_bank #(.MAX_DIM(MD), .MAX_STORE(MS), .ELEM_WIDTH(EW), .DIM_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wen(wen), .m(m), .n(n), .wr_mode(wr_mode), .wr_slot(wr_slot),
    .elem_in(elem_in), .elem_valid(elem_valid), .elem_end(elem_end), .abort(abort),
    .rd_en(rd_en), .rd_slot(rd_slot), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_m(rd_m), .rd_n(rd_n), .rd_valid(rd_valid), .rd_hit(rd_hit),
    .slot_valid(slot_valid), .busy(busy), .input_done(input_done), .dim_err(dim_err)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          hit;
    logic [EW-1:0] data;
    logic [DW-1:0] dm;
    logic [DW-1:0] dn;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  // Behavioural model: elements addressed by linear row-major index.
  logic [EW-1:0] mm [MS][MD][MD];
  bit            mv [MS];
  int            mdm [MS];
  int            mdn [MS];
  int            mptr, mtgt, midx;
  bit            mfill;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MS-1:0] mvvec();
    logic [MS-1:0] v;
    for (int s = 0; s < MS; s++) v[s] = mv[s];
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < MS; s++) begin
      mv[s] = 0; mdm[s] = 0; mdn[s] = 0;
      for (int r = 0; r < MD; r++)
        for (int c = 0; c < MD; c++) mm[s][r][c] = '0;
    end
    mptr = 0; mtgt = 0; midx = 0; mfill = 0;
  endtask

  task automatic do_idle();
    @(negedge clk);
  endtask

  task automatic do_wen(int mm_, int nn_, bit mode, int slot, bit with_elem = 0, int ev = 0);
    bit legal;
    int t;
    @(negedge clk);
    wen = 1'b1; m = DW'(mm_); n = DW'(nn_); wr_mode = mode; wr_slot = SW'(slot);
    elem_valid = with_elem; elem_in = EW'(ev);
    legal = (mm_ >= 1) && (mm_ <= MD) && (nn_ >= 1) && (nn_ <= MD) && (!mode || slot < MS);
    if (legal) begin
      t = mode ? slot : mptr;
      if (!mode) mptr = (mptr + 1) % MS;
      for (int r = 0; r < MD; r++)
        for (int c = 0; c < MD; c++) mm[t][r][c] = '0;
      mv[t] = 0; mdm[t] = mm_; mdn[t] = nn_;
      mfill = 1; mtgt = t; midx = 0;
    end
    @(negedge clk);
    wen = 1'b0; elem_valid = 1'b0;
    chk("wen_dim_err", dim_err, !legal);
    chk("wen_busy", busy, mfill);
    chk("wen_slot_valid", slot_valid, mvvec());
  endtask

  task automatic do_el(int v, bit vld, bit e);
    bit done;
    done = 0;
    @(negedge clk);
    elem_valid = vld; elem_end = e; elem_in = EW'(v);
    if (mfill) begin
      if (vld) begin
        mm[mtgt][midx / mdn[mtgt]][midx % mdn[mtgt]] = EW'(v);
        midx++;
      end
      if (midx == mdm[mtgt] * mdn[mtgt] || e) begin
        done = 1; mv[mtgt] = 1; mfill = 0;
      end
    end
    @(negedge clk);
    elem_valid = 1'b0; elem_end = 1'b0;
    chk("el_input_done", input_done, done);
    chk("el_busy", busy, mfill);
    chk("el_slot_valid", slot_valid, mvvec());
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    mfill = 0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_input_done", input_done, 0);
    chk("abort_slot_valid", slot_valid, mvvec());
  endtask

  task automatic do_rd_x(int s, int r, int c, bit hit, int data, int dm, int dn);
    rd_exp_t e;
    e.hit = hit; e.data = EW'(data); e.dm = DW'(dm); e.dn = DW'(dn);
    exp_q.push_back(e);
    @(negedge clk);
    rd_en = 1'b1; rd_slot = SW'(s); rd_row = DW'(r); rd_col = DW'(c);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_rd(int s, int r, int c);
    bit hit;
    hit = mv[s] && r < mdm[s] && c < mdn[s];
    do_rd_x(s, r, c, hit, hit ? int'(mm[s][r][c]) : 0, mv[s] ? mdm[s] : 0, mv[s] ? mdn[s] : 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL rd_unexpected observed rd_valid=1 expected no read pending");
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk("rd_hit", rd_hit, e.hit);
        chk("rd_data", rd_data, e.data);
        chk("rd_m", rd_m, e.dm);
        chk("rd_n", rd_n, e.dn);
      end
    end
  end

  initial begin
    rst = 1'b1; wen = 0; m = 0; n = 0; wr_mode = 0; wr_slot = 0; elem_in = 0;
    elem_valid = 0; elem_end = 0; abort = 0; rd_en = 0; rd_slot = 0; rd_row = 0; rd_col = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_slot_valid", slot_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_input_done", input_done, 0);
    chk("rst_dim_err", dim_err, 0);
    rst = 1'b0;

    // FIFO fill of all four slots with 2x3 matrices
    for (int s = 0; s < MS; s++) begin
      do_wen(2, 3, 0, 0);
      for (int e = 1; e <= 6; e++) do_el(e, 1, 0);
    end
    chk("fifo_all_valid", slot_valid, 4'b1111);
    do_rd_x(2, 1, 2, 1, 6, 2, 3);
    do_rd(3, 0, 1);
    // Fifth wen wraps to slot 0, which reads as a miss while filling
    do_wen(2, 3, 0, 0);
    chk("fifo_wrap_valid", slot_valid, 4'b1110);
    do_rd_x(0, 0, 0, 0, 0, 0, 0);
    for (int e = 10; e <= 15; e++) do_el(e, 1, 0);
    do_rd(0, 1, 0);

    // Early end zero-pads; surplus element in IDLE is dropped
    do_wen(3, 3, 0, 0);
    do_el(9, 1, 0); do_el(8, 1, 0); do_el(7, 1, 0); do_el(6, 1, 0);
    do_el(0, 0, 1);
    do_rd_x(1, 1, 0, 1, 6, 3, 3);
    do_rd_x(1, 1, 1, 1, 0, 3, 3);
    do_rd_x(1, 2, 2, 1, 0, 3, 3);
    do_el(8'h77, 1, 0);
    do_rd_x(1, 1, 1, 1, 0, 3, 3);
    do_el(0, 0, 1);

    // Rejected dimensions
    do_wen(0, 3, 0, 0);
    do_idle();
    chk("dim_err_pulse_end", dim_err, 0);
    do_wen(6, 2, 0, 0);
    do_wen(2, 0, 1, 1);

    // Explicit slot write leaves fifo_ptr alone
    do_wen(1, 1, 1, 2);
    do_el(8'h55, 1, 0);
    do_rd_x(2, 0, 0, 1, 8'h55, 1, 1);

    // Read port on a 2x2 in slot 1
    do_wen(2, 2, 1, 1);
    for (int e = 1; e <= 4; e++) do_el(e, 1, 0);
    do_rd_x(1, 1, 0, 1, 3, 2, 2);
    do_rd_x(1, 2, 0, 0, 0, 2, 2);

    // Next FIFO wen must land in slot 2
    do_wen(1, 2, 0, 0);
    do_el(8'hA1, 1, 0); do_el(8'hA2, 1, 0);
    do_rd_x(2, 0, 1, 1, 8'hA2, 1, 2);

    // Abort after five elements of a 3x3
    do_wen(3, 3, 0, 0);
    for (int e = 1; e <= 5; e++) do_el(e, 1, 0);
    do_abort();
    chk("abort_slot3_invalid", slot_valid[3], 0);
    do_rd_x(3, 0, 0, 0, 0, 0, 0);

    // wen with a same-cycle element restarts the fill and drops that element
    do_wen(2, 2, 1, 3);
    do_el(8'h11, 1, 0); do_el(8'h22, 1, 0);
    do_wen(2, 2, 1, 3, 1, 8'hEE);
    for (int e = 8'h31; e <= 8'h34; e++) do_el(e, 1, 0);
    do_rd_x(3, 0, 0, 1, 8'h31, 2, 2);
    do_rd_x(3, 1, 1, 1, 8'h34, 2, 2);

    // Element with elem_end in the same cycle is written before completion
    do_wen(2, 2, 1, 0);
    do_el(8'h40, 1, 1);
    do_rd_x(0, 0, 0, 1, 8'h40, 2, 2);
    do_rd_x(0, 0, 1, 1, 0, 2, 2);
    do_rd(2, 0, 0);

    // Async reset between edges, mid-fill and with a read in flight
    do_wen(3, 3, 1, 2);
    do_el(1, 1, 0); do_el(2, 1, 0);
    @(negedge clk);
    rd_en = 1'b1; rd_slot = 2'd1; rd_row = 0; rd_col = 0;
    @(posedge clk);
    #2;
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_slot_valid", slot_valid, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    do_rd_x(2, 0, 0, 0, 0, 0, 0);
    do_rd(1, 0, 0);

    repeat (2) @(negedge clk);
    chk("rd_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matrix_bank.md
Name: matrix_bank

Overview:
Parametrised multi-slot matrix store that succeeds the original single-mode storage block. Matrices arrive as a row-major element stream and land in one of MAX_STORE slots. The slot is chosen either by FIFO overwrite or by explicit selection. Compared with its predecessor, it adds dimension checking, early-terminate zero-padding, abort, and a registered random-access read port, so downstream operator units no longer need the whole array.

Parameters:
MAX_DIM, 5, maximum rows/cols per matrix
MAX_STORE, 4, number of slots (>=1)
ELEM_WIDTH, 8, element width in bits
DIM_WIDTH, 4, width of dimension/index fields (2^DIM_WIDTH > MAX_DIM)
SLOT_W (localparam), max(1, clog2(MAX_STORE)), slot index width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
wen  in  1  start new matrix (1-cycle pulse)
m  in  DIM_WIDTH  rows for new matrix
n  in  DIM_WIDTH  cols for new matrix
wr_mode  in  1  0 = FIFO overwrite slot, 1 = explicit slot wr_slot
wr_slot  in  SLOT_W  target slot when wr_mode=1
elem_in  in  ELEM_WIDTH  element data
elem_valid  in  1  one element per high cycle
elem_end  in  1  finish early; remaining elements stay zero
abort  in  1  discard matrix being filled
rd_en  in  1  read request
rd_slot  in  SLOT_W  read slot
rd_row  in  DIM_WIDTH  read row
rd_col  in  DIM_WIDTH  read col
rd_data  out  ELEM_WIDTH  read element (registered)
rd_m  out  DIM_WIDTH  stored rows of rd_slot (registered)
rd_n  out  DIM_WIDTH  stored cols of rd_slot (registered)
rd_valid  out  1  pulse, rd_* outputs valid
rd_hit  out  1  read address inside a valid matrix
slot_valid  out  MAX_STORE  per-slot complete-matrix flag
busy  out  1  high in FILL state
input_done  out  1  1-cycle pulse on matrix completion
dim_err  out  1  1-cycle pulse on rejected wen

Behaviour:
- Reset (async): state IDLE; all storage, dims, fifo_ptr, counters = 0; all outputs 0.
- States:
  - IDLE: busy=0.
  - FILL: busy=1. Holds tgt_slot, act_m, act_n, row_cnt, col_cnt.
- wen accept condition: 1<=m<=MAX_DIM, 1<=n<=MAX_DIM, and, if wr_mode=1, wr_slot<MAX_STORE.
- wen accepted, in either state, on the next edge:
  - tgt_slot = wr_mode ? wr_slot : fifo_ptr.
  - If wr_mode=0: fifo_ptr advances, wrapping MAX_STORE-1 -> 0. If wr_mode=1: fifo_ptr unchanged.
  - Every element of the target slot cleared to 0.
  - slot_valid[tgt] cleared; stored dims of the slot set to m, n.
  - Counters zeroed; state becomes FILL.
- wen in FILL: the previous partial slot stays invalid (implicit abort), then the new matrix starts.
- wen rejected: dim_err pulses next cycle; no other state change.
- elem_valid in FILL: elem_in is written at [row_cnt][col_cnt]. Row/col counters are used, not divide/modulo. col_cnt wraps at act_n-1 and increments row_cnt.
- The act_m*act_n-th element completes the matrix in the same edge: slot_valid[tgt]=1, input_done pulse the next cycle, state IDLE.
- elem_valid in IDLE: ignored. Surplus elements are dropped with no error.
- elem_end in FILL: completes the matrix as above; unwritten positions remain 0 (zero-pad).
- elem_end in IDLE: ignored.
- abort in FILL: state IDLE; slot_valid[tgt] stays 0; fifo_ptr is not rewound; no input_done.
- Same-cycle priority:
  - wen over abort, elem_end and elem_valid; the element in that cycle is dropped.
  - elem_valid together with elem_end: the element is written, then completion.
  - abort over elem_valid and elem_end.
- Read, 1-cycle latency. rd_en at edge k gives rd_valid=1 during cycle k+1, with:
  - rd_hit = slot_valid[rd_slot] && rd_slot<MAX_STORE && rd_row<stored_m && rd_col<stored_n.
  - rd_data = element if rd_hit, else 0.
  - rd_m/rd_n = stored dims if the slot is valid, else 0.
- rd_en low: rd_valid=0; rd_data/rd_m/rd_n hold their values.
- Read and write on the same edge: the read sees pre-edge contents. A slot under fill reads as miss.
- Reset mid-FILL or mid-read: everything returns to reset values immediately.

Test Plan:
- FIFO fill: MAX_STORE=4, wr_mode=0, four wens of 2x3 with elements 1..6 -> each input_done 1 cycle after the 6th element; slot_valid=4'b1111. A fifth wen overwrites slot 0 and slot_valid[0] drops until completion.
- Pad and surplus: wen 3x3, 4 elements (9,8,7,6), then elem_end -> row1 = [6,0,0], row2 = 0, input_done pulses. A later elem_valid in IDLE leaves the storage unchanged.
- Explicit and error cases:
  - wen m=0 -> dim_err pulse, busy stays 0.
  - wen m=6 -> dim_err pulse.
  - wr_mode=1, wr_slot=2, 1x1 elem 0x55 -> slot 2 = 0x55 and fifo_ptr unchanged.
- Read port: after a 2x2 [1,2;3,4] in slot 1, rd (1,1,0) -> next cycle rd_valid=1, rd_hit=1, rd_data=3, rd_m=2, rd_n=2. Read at (1,2,0) -> rd_hit=0, rd_data=0.
- Abort and re-wen: 3x3 with 5 elements then abort -> slot invalid, no input_done. A wen arriving together with elem_valid mid-fill -> element dropped, new fill starts with counters at 0.
- Async reset asserted mid-FILL between clock edges -> busy, slot_valid and rd_valid = 0 before the next edge.
